key_debounce: RTL
=================

// Module: key_debounce
// PURPOSE
//  Conditions the raw, active-low, bouncing push-button pins (KEY[3:0]) before they
//  reach the key PIO's in_port.
//  Per key:
//   - 2-FF synchroniser, then a counter-based debounce FSM.
//   - Drives a clean active-low level whose press is a single falling edge, for the
//     PIO edge capture.
//   - Emits one-cycle press/release strobes for local hardware consumers.
// PARAMETERS
//  N_KEYS           4       number of independent key channels
//  DEBOUNCE_CYCLES  500000  consecutive stable synchronised samples before a change is accepted (10 ms @ 50 MHz); legal range >= 2
//  CNT_W            derived localparam = $clog2(DEBOUNCE_CYCLES); not overridable
// PORTS
//  clk            in   1       system clock; single clock domain
//  reset_n        in   1       asynchronous, active-low reset
//  key_raw        in   N_KEYS  raw button pins, asynchronous, active-low (0 = pressed)
//  key_out        out  N_KEYS  debounced level, active-low; connects to PIO in_port
//  press_pulse    out  N_KEYS  1-cycle high strobe when key_out[i] falls (accepted press)
//  release_pulse  out  N_KEYS  1-cycle high strobe when key_out[i] rises (accepted release)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - sync regs = all 1s; every FSM -> UP with counter 0.
//   - key_out = all 1s; press_pulse = release_pulse = 0.
//  Synchroniser: s1 <= key_raw; s2 <= s1. The FSM samples s2 only.
//  Per-key FSM, 4 states; channels fully independent:
//   UP      key_out=1. If s2==0 -> ARM_DN, cnt<=0; else stay.
//   ARM_DN  key_out=1.
//            - If s2==1 -> UP, cnt<=0 (glitch rejected; no pulse).
//            - Else if cnt==DEBOUNCE_CYCLES-1 -> DOWN, key_out<=0, press_pulse<=1 for 1 cycle.
//            - Else cnt<=cnt+1.
//   DOWN    key_out=0. If s2==1 -> ARM_UP, cnt<=0; else stay.
//   ARM_UP  key_out=0.
//            - If s2==0 -> DOWN, cnt<=0 (no pulse).
//            - Else if cnt==DEBOUNCE_CYCLES-1 -> UP, key_out<=1, release_pulse<=1 for 1 cycle.
//            - Else cnt<=cnt+1.
//  Timing and latency:
//   - Outputs are registered.
//   - A raw change that is stable from before rising edge E1 moves key_out on edge
//     E1+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges total.
//   - The pulse asserts on the same edge as the key_out change and is high for exactly 1 cycle.
//  Glitches and bounce:
//   - A bounce of any width that ends before the counter reaches DEBOUNCE_CYCLES-1
//     restarts the count from 0 on the next opposite sample.
//   - press_pulse and release_pulse are never high together on one key.
//   - At most one press per accepted DOWN, and one release per accepted UP.
//  Counter: CNT_W bits; never exceeds DEBOUNCE_CYCLES-1 and never wraps.
//  Simultaneous events: any subset of keys may change on the same cycle; each key
//   produces its own pulse on the same edge, with no priority or interaction.
//  Mid-operation reset: reset_n low in any state forces the reset values immediately.
//   - A key held down through reset release is re-qualified from UP.
//   - It yields key_out fall plus press_pulse DEBOUNCE_CYCLES+3 edges after release.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, N_KEYS=4)
//  1 Reset: hold reset_n=0, key_raw=4'h0 -> key_out=4'hF, pulses=0 throughout.
//  2 Clean press: key_raw[0] 1->0 held, stable before edge E1 -> key_out[0]=0 and
//    press_pulse[0]=1 after edge E1+6, for one cycle only; other bits unchanged.
//  3 Bounce reject: key_raw[1] low for 3 cycles, high 1, low 3, high
//    -> key_out[1] stays 1; no pulses.
//  4 Release: from pressed, key_raw[0] 0->1 held -> key_out[0]=1 and
//    release_pulse[0]=1 after edge E1+6.
//  5 Simultaneous: key_raw 4'hF->4'h5 at one edge -> key_out=4'h5 and
//    press_pulse=4'hA on the same edge.
//  6 Reset mid-ARM_DN: key_raw[2]=0; assert reset_n at count 2; release with
//    key_raw[2] still 0 -> key_out[2]=1 during reset, falls DEBOUNCE_CYCLES+3
//    edges after release with one press_pulse.

Source files
------------

// File: rtl/key_debounce.sv
// Purpose : synchronise and debounce raw active-low push buttons; emit clean
//           active-low levels plus one-cycle press/release strobes per key.
// Latency : a raw change stable before edge E1 moves key_out on edge
//           E1+DEBOUNCE_CYCLES+2; strobes assert on that same edge.
// Backpressure: none; the block is free-running with no flow control.
//
// Ports:
//   clk           system clock, single domain
//   reset_n       asynchronous assert, active-low reset
//   key_raw       raw button pins, asynchronous, active-low (0 = pressed)
//   key_out       debounced level, active-low, registered
//   press_pulse   1-cycle high strobe when key_out[i] falls
//   release_pulse 1-cycle high strobe when key_out[i] rises
module key_debounce #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_out,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      UP     = 2'd0,
      ARM_DN = 2'd1,
      DOWN   = 2'd2,
      ARM_UP = 2'd3
   } state_t;

   // Two-stage synchroniser; idles at 1 (released) so reset never looks like a press.
   logic [N_KEYS-1:0] s1;
   logic [N_KEYS-1:0] s2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '1;
         s2 <= '1;
      end else begin
         s1 <= key_raw;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             key_q;
      logic             press_q;
      logic             release_q;
      logic             key_nxt;
      logic             press_nxt;
      logic             release_nxt;

      // State register, counter and registered outputs.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state     <= UP;
            cnt       <= '0;
            key_q     <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_q     <= key_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
         end
      end

      // Next-state and counter logic. The counter only advances while arming,
      // and stops at CNT_MAX because that value always leaves the arming state.
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         unique case (state)
            UP: begin
               if (!s2[i]) begin
                  state_nxt = ARM_DN;
                  cnt_nxt   = '0;
               end
            end
            ARM_DN: begin
               if (s2[i]) begin
                  state_nxt = UP;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_MAX) begin
                  state_nxt = DOWN;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            DOWN: begin
               if (s2[i]) begin
                  state_nxt = ARM_UP;
                  cnt_nxt   = '0;
               end
            end
            ARM_UP: begin
               if (!s2[i]) begin
                  state_nxt = DOWN;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_MAX) begin
                  state_nxt = UP;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = UP;
               cnt_nxt   = '0;
            end
         endcase
      end

      // Output logic: the level follows the committed side of the FSM; strobes
      // fire only on an accepted arm->settled transition, so they are mutually
      // exclusive and occur once per accepted change.
      always_comb begin
         key_nxt     = (state_nxt == UP) || (state_nxt == ARM_DN);
         press_nxt   = (state == ARM_DN) && (state_nxt == DOWN);
         release_nxt = (state == ARM_UP) && (state_nxt == UP);
      end

      assign key_out[i]       = key_q;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
   end

endmodule
